// File: rtl/mioc_nor2_nmos_tc_pkg.sv
// Shared types and helpers for the NOR2 characterisation wrapper.
// The fault_sel codes here are used only when MIOC_NOR2_FAULT_INJ_EN is defined.
package mioc_nor2_pkg;

    typedef enum logic [1:0] {
        FLT_NONE = 2'b00,
        FLT_SA0  = 2'b01,
        FLT_SA1  = 2'b10,
        FLT_INV  = 2'b11
    } flt_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

    function automatic logic nor2(input logic a, input logic b);
        return ~(a | b);
    endfunction

    function automatic logic apply_fault(input logic r, input logic [1:0] sel);
        logic f;
        f = r;
        case (sel)
            FLT_NONE: f = r;
            FLT_SA0:  f = 1'b0;
            FLT_SA1:  f = 1'b1;
            FLT_INV:  f = ~r;
            default:  f = r;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mioc_nor2_nmos_tc_if.sv
// Bus between the pattern driver / readout logic and the NOR2 characterisation wrapper.
// The driver owns the master modport and the wrapper owns the slave modport.
interface mioc_nor2_nmos_tc_if
    import mioc_nor2_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

    logic             en;
    logic             clr;
    logic             in1;
    logic             in2;
    logic [1:0]       fault_sel;
    logic             z;
    logic             z_valid;
    logic [CNT_W-1:0] pat_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [3:0]       cov;

    modport master (
        output en, clr, in1, in2, fault_sel,
        input  z, z_valid, pat_cnt, hi_cnt, cov
    );

    modport slave (
        input  en, clr, in1, in2, fault_sel,
        output z, z_valid, pat_cnt, hi_cnt, cov
    );

endinterface

// File: rtl/mioc_nor2_nmos_tc_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset, synchronous clear
// and increment enable; it holds at all-ones instead of wrapping.
module mioc_nor2_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mioc_nor2_nmos_tc.sv
// Clocked NOR2 test wrapper: registers z = f(~(in1|in2)) and keeps pattern, output-high
// and input-coverage statistics. Define MIOC_NOR2_FAULT_INJ_EN to enable fault injection.
module mioc_nor2_nmos_tc
    import mioc_nor2_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mioc_nor2_nmos_tc_if.slave   bus
);

    logic r;
    logic fz;
    logic cnt_en;

    assign r = nor2(bus.in1, bus.in2);

`ifdef MIOC_NOR2_FAULT_INJ_EN
    assign fz = apply_fault(r, bus.fault_sel);
`else
    logic unused_fault_sel;
    assign unused_fault_sel = ^bus.fault_sel;
    assign fz = r;
`endif

    // clr drops the statistics for this sample, but z/z_valid still capture it.
    assign cnt_en = bus.en & ~bus.clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.z       <= 1'b0;
            bus.z_valid <= 1'b0;
            bus.cov     <= '0;
        end else begin
            bus.z_valid <= bus.en;
            if (bus.en) begin
                bus.z <= fz;
            end
            if (bus.clr) begin
                bus.cov <= '0;
            end else if (bus.en) begin
                bus.cov[{bus.in1, bus.in2}] <= 1'b1;
            end
        end
    end

    mioc_nor2_sat_cnt #(.W(CNT_W)) u_pat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (cnt_en),
        .cnt   (bus.pat_cnt)
    );

    mioc_nor2_sat_cnt #(.W(CNT_W)) u_hi_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (cnt_en & fz),
        .cnt   (bus.hi_cnt)
    );

endmodule

// File: tb/tb_mioc_nor2_nmos_tc.sv
// Directed bench for mioc_nor2_nmos_tc: a 16-bit and a 4-bit instance driven in lockstep,
// checked against a scoreboard. Fault steps apply when MIOC_NOR2_FAULT_INJ_EN is defined.
module tb_mioc_nor2_nmos_tc;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mioc_nor2_nmos_tc_if #(.CNT_W(16)) bus16 ();
    mioc_nor2_nmos_tc_if #(.CNT_W(4))  bus4 ();

    mioc_nor2_nmos_tc #(.CNT_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    mioc_nor2_nmos_tc #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    typedef struct packed {
        logic        z;
        logic        zv;
        logic [15:0] pat;
        logic [15:0] hi;
        logic [3:0]  cov;
        logic [3:0]  pat4;
        logic [3:0]  hi4;
    } exp_t;

    exp_t q[$];

    logic        m_z, m_zv;
    logic [15:0] m_pat, m_hi;
    logic [3:0]  m_cov, m_pat4, m_hi4;

    function automatic logic model_fault(input logic r, input logic [1:0] fs);
`ifdef MIOC_NOR2_FAULT_INJ_EN
        if (fs == 2'b01) return 1'b0;
        if (fs == 2'b10) return 1'b1;
        if (fs == 2'b11) return ~r;
        return r;
`else
        return r;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic e, input logic c,
                        input logic a, input logic b, input logic [1:0] fs);
        exp_t x;
        logic f;
        rst_n = rn;
        bus16.en = e;  bus16.clr = c;  bus16.in1 = a;  bus16.in2 = b;  bus16.fault_sel = fs;
        bus4.en  = e;  bus4.clr  = c;  bus4.in1  = a;  bus4.in2  = b;  bus4.fault_sel  = fs;
        if (!rn) begin
            m_z = 1'b0; m_zv = 1'b0; m_pat = '0; m_hi = '0; m_cov = '0; m_pat4 = '0; m_hi4 = '0;
        end else begin
            f = model_fault(!(a || b), fs);
            m_zv = e;
            if (e) m_z = f;
            if (c) begin
                m_pat = '0; m_hi = '0; m_cov = '0; m_pat4 = '0; m_hi4 = '0;
            end else if (e) begin
                if (m_pat != 16'hFFFF) m_pat = m_pat + 16'd1;
                if (m_pat4 != 4'd15) m_pat4 = m_pat4 + 4'd1;
                if (f && m_hi != 16'hFFFF) m_hi = m_hi + 16'd1;
                if (f && m_hi4 != 4'd15) m_hi4 = m_hi4 + 4'd1;
                m_cov[{a, b}] = 1'b1;
            end
        end
        x.z = m_z; x.zv = m_zv; x.pat = m_pat; x.hi = m_hi; x.cov = m_cov;
        x.pat4 = m_pat4; x.hi4 = m_hi4;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        check("z16",     32'(bus16.z),       32'(x.z));
        check("zv16",    32'(bus16.z_valid), 32'(x.zv));
        check("pat16",   32'(bus16.pat_cnt), 32'(x.pat));
        check("hi16",    32'(bus16.hi_cnt),  32'(x.hi));
        check("cov16",   32'(bus16.cov),     32'(x.cov));
        check("z4",      32'(bus4.z),        32'(x.z));
        check("zv4",     32'(bus4.z_valid),  32'(x.zv));
        check("pat4",    32'(bus4.pat_cnt),  32'(x.pat4));
        check("hi4",     32'(bus4.hi_cnt),   32'(x.hi4));
        check("cov4",    32'(bus4.cov),      32'(x.cov));
        check("inv16",   32'(bus16.hi_cnt <= bus16.pat_cnt), 32'd1);
    endtask

    initial begin
        // Reset with en=1, in=11 for two cycles
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        check("rst_z",   32'(bus16.z),       32'd0);
        check("rst_cov", 32'(bus16.cov),     32'd0);

        // Truth table
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        check("tt00_z",  32'(bus16.z), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        check("tt_pat",  32'(bus16.pat_cnt), 32'd4);
        check("tt_hi",   32'(bus16.hi_cnt),  32'd1);
        check("tt_cov",  32'(bus16.cov),     32'hF);

        // Hold: en=0 with toggling inputs, including a 00 that must not reach z
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'(i[0]), 1'(i[1]), 2'b00);
        end
        check("hold_z",  32'(bus16.z), 32'd0);

        // Clear collides with an accepted 00 sample
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        check("clr_z",   32'(bus16.z),       32'd1);
        check("clr_pat", 32'(bus16.pat_cnt), 32'd0);

        // fault_sel=11 on 01: ignored unless fault injection is built in
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);

        // Saturation of the 4-bit instance
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        end
        check("sat_pat4", 32'(bus4.pat_cnt), 32'd15);
        check("sat_hi4",  32'(bus4.hi_cnt),  32'd15);
        check("sat_pat16", 32'(bus16.pat_cnt), 32'd20);

`ifdef MIOC_NOR2_FAULT_INJ_EN
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        check("sa0_z",   32'(bus16.z),      32'd0);
        check("sa0_hi",  32'(bus16.hi_cnt), 32'd20);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11);
        check("inv_z",   32'(bus16.z),      32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
        check("sa1_z",   32'(bus16.z),      32'd1);
`endif

        // Mid-run reset beats clr and en
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        check("q_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
